// File: rtl/morse_key_classifier.sv
// rtl/morse_key_classifier.sv - Morse key line to one-cycle DIT/DAH/GAP/SPACE element codes
module morse_key_classifier #(
   parameter int unsigned CYCLES_PER_UNIT = 1200000,
   parameter int unsigned DAH_UNITS       = 2,
   parameter int unsigned GAP_UNITS       = 3,
   parameter int unsigned SPACE_UNITS     = 7,
   parameter int unsigned MIN_PRESS       = 2,
   parameter int unsigned CNT_W           = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   output logic [2:0] sym,
   output logic       key_sync
);

   localparam logic [2:0] SYM_WAIT  = 3'd0;
   localparam logic [2:0] SYM_DIT   = 3'd1;
   localparam logic [2:0] SYM_DAH   = 3'd2;
   localparam logic [2:0] SYM_GAP   = 3'd3;
   localparam logic [2:0] SYM_SPACE = 3'd4;

   // Thresholds are formed at counter width so they compare directly against the counters.
   localparam logic [CNT_W-1:0] UNIT       = CNT_W'(CYCLES_PER_UNIT);
   localparam logic [CNT_W-1:0] DAH_TH     = CNT_W'(DAH_UNITS) * UNIT;
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_UNITS) * UNIT - CNT_W'(1);
   localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACE_UNITS - GAP_UNITS) * UNIT - CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_TH     = CNT_W'(MIN_PRESS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DOWN   = 2'd1,
      UP     = 2'd2,
      GAPPED = 2'd3
   } state_t;

   state_t           state, state_nx;
   state_t           ret, ret_nx;
   logic             s1, s2;
   logic             boot, armed;
   logic [CNT_W-1:0] press, press_nx;
   logic [CNT_W-1:0] sil, sil_nx;
   logic [2:0]       sym_nx;

   assign key_sync = s2;

   // Two-flop synchronizer plus arming: a press already held across reset must be
   // released (s1 seen low after the first clock) before a new press is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         boot  <= 1'b0;
         armed <= 1'b0;
      end else begin
         s1    <= key;
         s2    <= s1;
         boot  <= 1'b1;
         armed <= armed | (boot & ~s1);
      end
   end

   // State, return state, counters and the registered element code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ret   <= IDLE;
         press <= '0;
         sil   <= '0;
         sym   <= SYM_WAIT;
      end else begin
         state <= state_nx;
         ret   <= ret_nx;
         press <= press_nx;
         sil   <= sil_nx;
         sym   <= sym_nx;
      end
   end

   // Next-state logic: classify presses on release, time silences for GAP/SPACE.
   always_comb begin
      state_nx = state;
      ret_nx   = ret;
      press_nx = press;
      sil_nx   = sil;
      sym_nx   = SYM_WAIT;
      case (state)
         IDLE: begin
            sil_nx = '0;
            if (s2 && armed) begin
               state_nx = DOWN;
               ret_nx   = IDLE;
               press_nx = CNT_ONE;
            end
         end
         DOWN: begin
            if (s2) begin
               press_nx = (press == CNT_MAX) ? press : press + CNT_ONE;
            end else begin
               sil_nx = '0;
               if (press < MIN_TH) begin
                  // Glitch: resume whatever was pending before the press.
                  state_nx = ret;
               end else begin
                  sym_nx   = (press < DAH_TH) ? SYM_DIT : SYM_DAH;
                  state_nx = UP;
               end
            end
         end
         UP: begin
            if (s2) begin
               state_nx = DOWN;
               ret_nx   = UP;
               press_nx = CNT_ONE;
               sil_nx   = '0;
            end else if (sil == GAP_LAST) begin
               sym_nx   = SYM_GAP;
               state_nx = GAPPED;
               sil_nx   = '0;
            end else begin
               sil_nx = (sil == CNT_MAX) ? sil : sil + CNT_ONE;
            end
         end
         GAPPED: begin
            if (s2) begin
               state_nx = DOWN;
               ret_nx   = GAPPED;
               press_nx = CNT_ONE;
               sil_nx   = '0;
            end else if (sil == SPACE_LAST) begin
               sym_nx   = SYM_SPACE;
               state_nx = IDLE;
               sil_nx   = '0;
            end else begin
               sil_nx = (sil == CNT_MAX) ? sil : sil + CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_morse_key_classifier.sv
// tb/tb_morse_key_classifier.sv - directed self-checking bench for morse_key_classifier
module tb_morse_key_classifier;

   logic       clk;
   logic       reset;
   logic       key;
   logic [2:0] sym;
   logic       key_sync;

   int total;
   int bad;
   int cyc;
   logic [2:0] ev_code[$];
   int         ev_cyc[$];

   morse_key_classifier #(
      .CYCLES_PER_UNIT(4),
      .DAH_UNITS(2),
      .GAP_UNITS(3),
      .SPACE_UNITS(7),
      .MIN_PRESS(2),
      .CNT_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key(key),
      .sym(sym),
      .key_sync(key_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock; sample 1 time unit after the edge and log every non-WAIT code.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (sym !== 3'd0) begin
         ev_code.push_back(sym);
         ev_cyc.push_back(cyc);
      end
   endtask

   task automatic clear_log();
      ev_code.delete();
      ev_cyc.delete();
   endtask

   // Key held for n sampling edges; the element appears 3 ticks after release.
   task automatic press(input int n);
      key = 1'b1;
      repeat (n) tick();
      key = 1'b0;
   endtask

   function automatic int letter_of(input int len, input int bits);
      if (len == 1 && bits == 0) return 69;
      if (len == 1 && bits == 1) return 84;
      if (len == 2 && bits == 1) return 65;
      if (len == 3 && bits == 0) return 83;
      if (len == 3 && bits == 7) return 79;
      return 63;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      key   = 1'b0;
      repeat (3) tick();
      total++; if (sym !== 3'd0) begin bad++; $display("FAIL reset_sym: got %0d want 0", sym); end
      total++; if (key_sync !== 1'b0) begin bad++; $display("FAIL reset_key_sync: got %0d want 0", key_sync); end
      reset = 1'b0;
      repeat (5) tick();
      press(4);
      repeat (3) tick();
      total++; if (sym !== 3'd1) begin bad++; $display("FAIL pre_reset_dit: got %0d want 1", sym); end
      key   = 1'b1;
      repeat (6) tick();
      total++; if (key_sync !== 1'b1) begin bad++; $display("FAIL held_key_sync: got %0d want 1", key_sync); end
      reset = 1'b1;
      #1;
      total++; if (key_sync !== 1'b0) begin bad++; $display("FAIL async_reset_key_sync: got %0d want 0", key_sync); end
      total++; if (sym !== 3'd0) begin bad++; $display("FAIL async_reset_sym: got %0d want 0", sym); end
      clear_log();
      repeat (2) tick();
      total++; if (key_sync !== 1'b0) begin bad++; $display("FAIL in_reset_key_sync: got %0d want 0", key_sync); end
      reset = 1'b0;
      repeat (10) tick();
      total++; if (key_sync !== 1'b1) begin bad++; $display("FAIL post_reset_key_sync: got %0d want 1", key_sync); end
      key = 1'b0;
      repeat (40) tick();
      total++; if (ev_code.size() !== 0) begin bad++; $display("FAIL discarded_press: got %0d codes want 0", ev_code.size()); end
   endtask

   task automatic test_press_boundary();
      int c0;
      int lens[4] = '{7, 8, 2, 1};
      logic [2:0] want[4] = '{3'd1, 3'd2, 3'd1, 3'd0};
      for (int i = 0; i < 4; i++) begin
         clear_log();
         c0 = cyc;
         press(lens[i]);
         repeat (40) tick();
         if (want[i] == 3'd0) begin
            total++; if (ev_code.size() !== 0) begin bad++; $display("FAIL glitch_press len=%0d: got %0d codes want 0", lens[i], ev_code.size()); end
         end else begin
            total++; if (ev_code.size() !== 3) begin bad++; $display("FAIL press_count len=%0d: got %0d codes want 3", lens[i], ev_code.size()); end
            total++; if (ev_code[0] !== want[i]) begin bad++; $display("FAIL press_code len=%0d: got %0d want %0d", lens[i], ev_code[0], want[i]); end
            total++; if (ev_cyc[0] !== c0 + lens[i] + 3) begin bad++; $display("FAIL press_latency len=%0d: got %0d want %0d", lens[i], ev_cyc[0], c0 + lens[i] + 3); end
         end
      end
   endtask

   task automatic test_gap_space();
      int t;
      clear_log();
      t = cyc + 7;
      press(4);
      repeat (3 + 28 + 100) tick();
      total++; if (ev_code.size() !== 3) begin bad++; $display("FAIL gs_count: got %0d want 3", ev_code.size()); end
      else begin
         total++; if (ev_code[0] !== 3'd1 || ev_cyc[0] !== t) begin bad++; $display("FAIL gs_dit: got %0d@%0d want 1@%0d", ev_code[0], ev_cyc[0], t); end
         total++; if (ev_code[1] !== 3'd3 || ev_cyc[1] !== t + 12) begin bad++; $display("FAIL gs_gap: got %0d@%0d want 3@%0d", ev_code[1], ev_cyc[1], t + 12); end
         total++; if (ev_code[2] !== 3'd4 || ev_cyc[2] !== t + 28) begin bad++; $display("FAIL gs_space: got %0d@%0d want 4@%0d", ev_code[2], ev_cyc[2], t + 28); end
      end
   endtask

   task automatic test_repress_letter_a();
      int t;
      int len;
      int bits;
      int letter;
      clear_log();
      t = cyc + 7;
      press(4);
      // key rises after tick t+8, so s2 rises 10 cycles after the DIT cycle
      repeat (11) tick();
      press(8);
      repeat (40) tick();
      total++; if (ev_code.size() !== 4) begin bad++; $display("FAIL a_count: got %0d want 4", ev_code.size()); end
      else begin
         total++; if (ev_code[1] !== 3'd2 || ev_cyc[1] !== t + 19) begin bad++; $display("FAIL a_no_gap_then_dah: got %0d@%0d want 2@%0d", ev_code[1], ev_cyc[1], t + 19); end
         total++; if (ev_code[2] !== 3'd3) begin bad++; $display("FAIL a_gap: got %0d want 3", ev_code[2]); end
         len = 0; bits = 0; letter = 0;
         for (int i = 0; i < ev_code.size(); i++) begin
            if (ev_code[i] == 3'd3) begin
               letter = letter_of(len, bits);
               break;
            end
            len++;
            bits = bits * 2 + ((ev_code[i] == 3'd2) ? 1 : 0);
         end
         total++; if (letter !== 65) begin bad++; $display("FAIL a_letter: got %0d want 65", letter); end
      end
   endtask

   task automatic test_sos();
      logic [2:0] exp_sos[13] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd1, 3'd1, 3'd1, 3'd3, 3'd4};
      int exp_let[3] = '{83, 79, 83};
      int len;
      int bits;
      int n_let;
      int adjacent;
      clear_log();
      for (int l = 0; l < 3; l++) begin
         for (int e = 0; e < 3; e++) begin
            press((l == 1) ? 8 : 4);
            if (e < 2) repeat (4) tick();
         end
         if (l < 2) repeat (16) tick();
         else repeat (40) tick();
      end
      total++; if (ev_code.size() !== 13) begin bad++; $display("FAIL sos_count: got %0d want 13", ev_code.size()); end
      else begin
         for (int i = 0; i < 13; i++) begin
            total++; if (ev_code[i] !== exp_sos[i]) begin bad++; $display("FAIL sos_code[%0d]: got %0d want %0d", i, ev_code[i], exp_sos[i]); end
         end
         adjacent = 0;
         for (int i = 1; i < 13; i++) if (ev_cyc[i] - ev_cyc[i-1] < 2) adjacent++;
         total++; if (adjacent !== 0) begin bad++; $display("FAIL sos_one_cycle: got %0d adjacent codes want 0", adjacent); end
         len = 0; bits = 0; n_let = 0;
         for (int i = 0; i < 13; i++) begin
            if (ev_code[i] == 3'd3) begin
               total++; if (letter_of(len, bits) !== exp_let[n_let]) begin bad++; $display("FAIL sos_letter[%0d]: got %0d want %0d", n_let, letter_of(len, bits), exp_let[n_let]); end
               n_let++; len = 0; bits = 0;
            end else if (ev_code[i] != 3'd4) begin
               len++;
               bits = bits * 2 + ((ev_code[i] == 3'd2) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_glitch_in_up();
      int t;
      clear_log();
      t = cyc + 7;
      press(4);
      // key high for one edge after tick t+4: s2 high one cycle, 6 cycles after the DIT
      repeat (7) tick();
      press(1);
      repeat (60) tick();
      // state is back in UP with silence 0 after tick t+8, so GAP lands at t+20
      total++; if (ev_code.size() !== 3) begin bad++; $display("FAIL glitch_count: got %0d want 3", ev_code.size()); end
      else begin
         total++; if (ev_code[1] !== 3'd3 || ev_cyc[1] !== t + 20) begin bad++; $display("FAIL glitch_gap: got %0d@%0d want 3@%0d", ev_code[1], ev_cyc[1], t + 20); end
         total++; if (ev_code[2] !== 3'd4 || ev_cyc[2] !== t + 36) begin bad++; $display("FAIL glitch_space: got %0d@%0d want 4@%0d", ev_code[2], ev_cyc[2], t + 36); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      reset = 1'b1;
      key   = 1'b0;
      test_reset();
      test_press_boundary();
      test_gap_space();
      test_repress_letter_a();
      test_sos();
      test_glitch_in_up();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
